// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with run/drain control, a per-run period budget and strobes.
// Define CLKDIV_CTRL_SHADOW_EN to accept a reconfiguration while running (applied at a period boundary).
module clkdiv_ctrl #(
   parameter int CNT_WIDTH   = 4,
   parameter int PULSE_WIDTH = 8,
   parameter int DIV_RESET   = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CNT_WIDTH-1:0]   cfg_div,
   input  logic [PULSE_WIDTH-1:0] cfg_pulses,
   input  logic                   start,
   input  logic                   stop,
   output logic                   out_clk_div,
   output logic                   tick,
   output logic                   done,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]   div_q, div_d;
   logic [PULSE_WIDTH-1:0] per_q, per_d;
   logic [PULSE_WIDTH-1:0] pulses_q, pulses_d;
   logic                   out_q, out_d;
   logic                   tick_q, tick_d;
   logic                   done_q, done_d;

   logic hit, rise, fall, last, xfer, sh_pend;

`ifdef CLKDIV_CTRL_SHADOW_EN
   logic                   sh_full_q, sh_full_d;
   logic [CNT_WIDTH-1:0]   sh_div_q, sh_div_d;
   logic [PULSE_WIDTH-1:0] sh_pulses_q, sh_pulses_d;

   assign sh_pend   = sh_full_q;
   assign cfg_ready = (state_q == IDLE) || ((state_q == RUN) && !sh_full_q);
`else
   assign sh_pend   = 1'b0;
   assign cfg_ready = (state_q == IDLE);
`endif

   assign hit  = (cnt_q == div_q);
   assign rise = hit && !out_q;
   assign fall = hit && out_q;
   assign last = (pulses_q != '0) && (per_q == pulses_q);
   assign xfer = cfg_valid && cfg_ready;

   assign out_clk_div = out_q;
   assign tick        = tick_q;
   assign done        = done_q;
   assign busy        = (state_q != IDLE);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      per_d    = per_q;
      pulses_d = pulses_q;
      out_d    = out_q;
      tick_d   = 1'b0;
      done_d   = 1'b0;
`ifdef CLKDIV_CTRL_SHADOW_EN
      sh_full_d   = sh_full_q;
      sh_div_d    = sh_div_q;
      sh_pulses_d = sh_pulses_q;
`endif

      // Half-period counter and output toggle, shared by RUN and DRAIN.
      if (state_q != IDLE) begin
         if (hit) begin
            cnt_d = '0;
            out_d = !out_q;
            if (rise) begin
               tick_d = 1'b1;
               if (per_q != '1) per_d = per_q + PULSE_WIDTH'(1);
            end
         end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (xfer) begin
               div_d    = cfg_div;
               pulses_d = cfg_pulses;
            end
            if (start && !stop) begin
               state_d = RUN;
               cnt_d   = '0;
               per_d   = '0;
               out_d   = 1'b0;
            end
         end
         RUN: begin
`ifdef CLKDIV_CTRL_SHADOW_EN
            if (xfer) begin
               sh_full_d   = 1'b1;
               sh_div_d    = cfg_div;
               sh_pulses_d = cfg_pulses;
            end
`endif
            // A boundary that applies a pending shadow never completes the old budget.
            if (fall && last && !sh_pend) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (stop) begin
               state_d = DRAIN;
`ifdef CLKDIV_CTRL_SHADOW_EN
            end else if (fall && sh_full_q) begin
               div_d     = sh_div_q;
               pulses_d  = sh_pulses_q;
               per_d     = '0;
               sh_full_d = 1'b0;
`endif
            end
         end
         DRAIN: begin
            if (!out_q) begin
               state_d = IDLE;
               cnt_d   = '0;
               out_d   = 1'b0;
               tick_d  = 1'b0;
               per_d   = per_q;
            end else if (fall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef CLKDIV_CTRL_SHADOW_EN
      // Leaving RUN (completion or stop) discards any pending shadow.
      if (state_d != RUN) sh_full_d = 1'b0;
`endif
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= CNT_WIDTH'(DIV_RESET);
         per_q    <= '0;
         pulses_q <= '0;
         out_q    <= 1'b0;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         per_q    <= per_d;
         pulses_q <= pulses_d;
         out_q    <= out_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
      end
   end

`ifdef CLKDIV_CTRL_SHADOW_EN
   always_ff @(posedge clk) begin
      if (rst) sh_full_q <= 1'b0;
      else     sh_full_q <= sh_full_d;
   end

   // NOTE: the shadow payload carries no reset; it is only read while sh_full_q is set.
   always_ff @(posedge clk) begin
      sh_div_q    <= sh_div_d;
      sh_pulses_q <= sh_pulses_d;
   end
`endif

endmodule
